cfg_scan_memory: RTL and testbench

//   Double-buffered, scan-loaded configuration memory. Serial data fills a shadow chain while the active

---
 rtl/cfg_pkg.sv | 34 +++
 rtl/cfg_scan_memory_if.sv | 34 +++
 rtl/cfg_shadow_chain.sv | 49 ++++
 rtl/cfg_scan_memory.sv | 89 ++++++++
 tb/tb_cfg_scan_memory.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// Shared sizing helpers, defaults and header-region field map for the scan-loaded config store.
// No logic here; consumed by the chain, the top level and the bus interface.
package cfg_pkg;

    localparam int CFG_DATA_W_DEF = 8;
    localparam int CFG_DEPTH_DEF  = 128;

    // Bit offsets of the engine header region inside the flattened active image
    localparam int HDR_STATE_OFF   = 0;
    localparam int HDR_STATE_LEN   = 8;
    localparam int HDR_TRANS_OFF   = 8;
    localparam int HDR_TRANS_LEN   = 16;
    localparam int HDR_CLK_DIV_OFF = 24;
    localparam int HDR_CLK_DIV_LEN = 8;

    typedef struct packed {
        logic valid;
        logic err;
    } cfg_status_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int CFG_TOTAL_BITS(input int depth, input int width);
        return depth * width;
    endfunction

endpackage

// File: rtl/cfg_scan_memory_if.sv
// Scan, commit, status and read-port bundle of the config store.
// master drives scan/commit/addresses; slave is the memory.
interface cfg_scan_memory_if
    import cfg_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W_DEF,
    parameter int DEPTH  = CFG_DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 8
) ();

    localparam int CNT_W = clog2(CFG_TOTAL_BITS(DEPTH, DATA_W) + 1);

    logic                     scan_in;
    logic                     scan_en;
    logic                     scan_out;
    logic                     commit;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     cfg_valid;
    logic                     cfg_err;
    logic [CNT_W-1:0]         bit_count;

    modport master (
        output scan_in, scan_en, commit, rd_addr,
        input  scan_out, rd_data, cfg_valid, cfg_err, bit_count
    );

    modport slave (
        input  scan_in, scan_en, commit, rd_addr,
        output scan_out, rd_data, cfg_valid, cfg_err, bit_count
    );

endinterface

// File: rtl/cfg_shadow_chain.sv
// Shadow scan chain with saturating bit counter and overflow flag; one bit per scan_en cycle.
// Latency: scan_out is the chain tail register; backpressure: none, every shift is accepted.
module cfg_shadow_chain
    import cfg_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W_DEF,
    parameter int DEPTH  = CFG_DEPTH_DEF,
    localparam int TOTAL = CFG_TOTAL_BITS(DEPTH, DATA_W),
    localparam int CNT_W = clog2(TOTAL + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_in,
    input  logic             shift_en,
    input  logic             clear,
    output logic             scan_out,
    output logic [TOTAL-1:0] image,
    output logic             full,
    output logic             ovf,
    output logic [CNT_W-1:0] bit_count
);

    // Word i lives at image[i*DATA_W +: DATA_W]; a word's LSB is fed by the
    // previous word's MSB, so the whole chain is one flat shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            image     <= '0;
            bit_count <= '0;
            ovf       <= 1'b0;
        end else begin
            if (shift_en) begin
                image <= {image[TOTAL-2:0], scan_in};
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    bit_count <= bit_count + CNT_W'(1);
                end
            end
            if (clear) begin
                bit_count <= '0;
                ovf       <= 1'b0;
            end
        end
    end

    assign full     = (bit_count == CNT_W'(TOTAL));
    assign scan_out = image[TOTAL-1];

endmodule

// File: rtl/cfg_scan_memory.sv
// Double-buffered config memory: shadow chain loads serially, commit swaps it into the active copy.
// Latency: reads 1 cycle from active; backpressure: none, commits during a shift are rejected.
module cfg_scan_memory
    import cfg_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W_DEF,
    parameter int DEPTH  = CFG_DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    cfg_scan_memory_if.slave bus
);

    localparam int TOTAL = CFG_TOTAL_BITS(DEPTH, DATA_W);
    localparam int CNT_W = clog2(TOTAL + 1);
    localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [TOTAL-1:0]  shadow_image;
    logic              shadow_full;
    logic              shadow_ovf;
    logic [CNT_W-1:0]  shadow_count;
    logic              commit_eval;
    logic              commit_ok;
    logic [DATA_W-1:0] active_mem [DEPTH];
    cfg_status_t       status_q;

    // A commit coinciding with a shift never reaches the evaluator
    assign commit_eval = bus.commit & ~bus.scan_en;
    assign commit_ok   = commit_eval & shadow_full & ~shadow_ovf;

    cfg_shadow_chain #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_chain (
        .clk       (clk),
        .reset     (reset),
        .scan_in   (bus.scan_in),
        .shift_en  (bus.scan_en),
        .clear     (commit_eval),
        .scan_out  (bus.scan_out),
        .image     (shadow_image),
        .full      (shadow_full),
        .ovf       (shadow_ovf),
        .bit_count (shadow_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_mem[i] <= '0;
            end
            status_q <= '0;
        end else if (commit_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_mem[i] <= shadow_image[i*DATA_W +: DATA_W];
            end
            status_q <= '{valid: 1'b1, err: 1'b0};
        end else if (bus.commit) begin
            status_q.err <= 1'b1;
        end
    end

    assign bus.cfg_valid = status_q.valid;
    assign bus.cfg_err   = status_q.err;
    assign bus.bit_count = shadow_count;

    // Reads sample active before any same-cycle commit lands
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_q;

        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
            end else if (32'(addr) < DEPTH) begin
                data_q <= active_mem[addr[IDX_W-1:0]];
            end else begin
                data_q <= '0;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = data_q;
    end

endmodule

// File: tb/tb_cfg_scan_memory.sv
// Self-checking bench for cfg_scan_memory at DATA_W=8, DEPTH=4, NUM_RD=2.
// A bit-history model predicts every output each cycle; directed steps add literal checks.
module tb_cfg_scan_memory;

    localparam int DW  = 8;
    localparam int DP  = 4;
    localparam int NR  = 2;
    localparam int AW  = 8;
    localparam int TOT = DW * DP;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cfg_scan_memory_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ADDR_W(AW)) bus ();

    cfg_scan_memory #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    // Model: every bit ever shifted (window of the last TOT), active words, read regs, flags
    bit         hist [$];
    logic [7:0] m_act [DP];
    logic [7:0] m_rd  [NR];
    logic       m_valid;
    logic       m_err;
    int         m_cnt;
    int         ma;
    logic [31:0] cap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                hist.delete();
                for (int i = 0; i < TOT; i++) hist.push_back(1'b0);
                for (int i = 0; i < DP; i++) m_act[i] = 8'h00;
                for (int k = 0; k < NR; k++) m_rd[k] = 8'h00;
                m_valid = 1'b0;
                m_err   = 1'b0;
                m_cnt   = 0;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    ma = int'(bus.rd_addr[k*AW +: AW]);
                    if (ma < DP) m_rd[k] = m_act[ma];
                    else         m_rd[k] = 8'h00;
                end
                if (bus.commit && !bus.scan_en) begin
                    // Oldest bit in the window is the MSB of the highest word
                    if (m_cnt == TOT) begin
                        for (int w = 0; w < DP; w++)
                            for (int j = 0; j < DW; j++)
                                m_act[w][DW-1-j] = hist[(DP-1-w)*DW + j];
                        m_valid = 1'b1;
                        m_err   = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_cnt = 0;
                end
                if (bus.scan_en) begin
                    hist.push_back(bus.scan_in);
                    void'(hist.pop_front());
                    m_cnt++;
                    if (bus.commit) m_err = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("scan_out",  64'(bus.scan_out),  64'(hist[0]));
                chk("cfg_valid", 64'(bus.cfg_valid), 64'(m_valid));
                chk("cfg_err",   64'(bus.cfg_err),   64'(m_err));
                chk("bit_count", 64'(bus.bit_count), 64'((m_cnt > TOT) ? TOT : m_cnt));
                chk("rd_data0",  64'(bus.rd_data[7:0]),  64'(m_rd[0]));
                chk("rd_data1",  64'(bus.rd_data[15:8]), 64'(m_rd[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.scan_en = 1'b1;
            bus.scan_in = v[i];
            tick();
        end
        bus.scan_en = 1'b0;
        bus.scan_in = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    initial begin
        bus.scan_in = 1'b0;
        bus.scan_en = 1'b0;
        bus.commit  = 1'b0;
        bus.rd_addr = '0;
        reset = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        chk("rst_rd_data",   64'(bus.rd_data),   64'h0);
        chk("rst_scan_out",  64'(bus.scan_out),  64'h0);
        chk("rst_cfg_valid", 64'(bus.cfg_valid), 64'h0);
        chk("rst_cfg_err",   64'(bus.cfg_err),   64'h0);
        chk("rst_bit_count", 64'(bus.bit_count), 64'h0);
        reset = 1'b0;
        tick();

        // Full load and commit
        shift_bits(64'hD4C3B2A1, 32);
        chk("load_count", 64'(bus.bit_count), 64'd32);
        do_commit();
        chk("t2_valid", 64'(bus.cfg_valid), 64'h1);
        chk("t2_err",   64'(bus.cfg_err),   64'h0);
        chk("t2_count", 64'(bus.bit_count), 64'h0);
        bus.rd_addr = {8'd3, 8'd0};
        tick();
        chk("t2_rd", 64'(bus.rd_data), 64'hD4A1);

        // Short load rejected
        shift_bits(64'h12345678, 31);
        do_commit();
        chk("t3_err",   64'(bus.cfg_err),   64'h1);
        chk("t3_valid", 64'(bus.cfg_valid), 64'h1);
        chk("t3_count", 64'(bus.bit_count), 64'h0);
        tick();
        chk("t3_rd", 64'(bus.rd_data), 64'hD4A1);

        // Long load rejected, then a good load clears the error
        shift_bits(64'h1_FFFF_0000, 33);
        chk("t4_sat", 64'(bus.bit_count), 64'd32);
        do_commit();
        chk("t4_err",   64'(bus.cfg_err),   64'h1);
        chk("t4_count", 64'(bus.bit_count), 64'h0);
        tick();
        chk("t4_rd", 64'(bus.rd_data), 64'hD4A1);
        shift_bits(64'hD4C3B2A1, 32);
        do_commit();
        chk("t4_err_clr", 64'(bus.cfg_err),   64'h0);
        chk("t4_valid",   64'(bus.cfg_valid), 64'h1);

        // Active copy is undisturbed while the next image shifts in
        bus.rd_addr = {8'd3, 8'd0};
        begin
            logic [31:0] img;
            img = 32'h11223344;
            for (int b = 3; b >= 0; b--) begin
                shift_bits(64'(img[b*8 +: 8]), 8);
                chk("t5_rd_during_load", 64'(bus.rd_data[7:0]), 64'hA1);
            end
        end
        do_commit();
        chk("t5_rd_commit_cycle", 64'(bus.rd_data[7:0]), 64'hA1);
        tick();
        chk("t5_rd_after", 64'(bus.rd_data[7:0]),  64'h44);
        chk("t5_rd1_after", 64'(bus.rd_data[15:8]), 64'h11);

        // Commit during a shift: shift happens, commit rejected, count kept
        shift_bits(64'b10110, 5);
        bus.scan_en = 1'b1;
        bus.scan_in = 1'b1;
        bus.commit  = 1'b1;
        tick();
        bus.commit  = 1'b0;
        bus.scan_en = 1'b0;
        chk("t6_err",   64'(bus.cfg_err),   64'h1);
        chk("t6_count", 64'(bus.bit_count), 64'd6);
        bus.rd_addr = {8'd0, 8'd4};
        tick();
        chk("t6_rd_oob", 64'(bus.rd_data), 64'h4400);

        // Shifting past a full load replays the loaded image at scan_out
        shift_bits(64'hD4C3B2A1, 32);
        for (int i = 31; i >= 0; i--) begin
            cap[i] = bus.scan_out;
            bus.scan_en = 1'b1;
            bus.scan_in = 1'b0;
            tick();
        end
        bus.scan_en = 1'b0;
        chk("t6_replay", 64'(cap), 64'hD4C3B2A1);
        chk("t6_sat", 64'(bus.bit_count), 64'd32);
        do_commit();
        chk("t6_ovf_reject", 64'(bus.cfg_err), 64'h1);
        tick();
        chk("t6_rd_kept", 64'(bus.rd_data), 64'h4400);

        // Reset wins over a coincident shift and commit
        shift_bits(64'hFF, 8);
        bus.scan_en = 1'b1;
        bus.scan_in = 1'b1;
        bus.commit  = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.scan_en = 1'b0;
        bus.commit  = 1'b0;
        chk("rst2_valid", 64'(bus.cfg_valid), 64'h0);
        chk("rst2_err",   64'(bus.cfg_err),   64'h0);
        chk("rst2_count", 64'(bus.bit_count), 64'h0);
        chk("rst2_scan",  64'(bus.scan_out),  64'h0);
        chk("rst2_rd",    64'(bus.rd_data),   64'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
